// File: rtl/light_step_timer.sv
// Step strobe and PWM brightness gate for the LED scanner.
// Speed and brightness are sampled only on step and PWM period boundaries.
module light_step_timer #(
  parameter int BASE_PERIOD = 1000,
  parameter int SPEED_WIDTH = 3,
  parameter int PWM_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pause,
  input  logic [SPEED_WIDTH-1:0] speed,
  input  logic [PWM_WIDTH-1:0]   brightness,
  output logic                   next_pos,
  output logic                   pwm_enable,
  output logic                   running
);

  localparam int PRE_W = (BASE_PERIOD > 2) ? $clog2(BASE_PERIOD) : 1;
  localparam logic [PRE_W-1:0]     PRE_MAX = PRE_W'(BASE_PERIOD - 1);
  localparam logic [PWM_WIDTH-1:0] PWM_MAX = PWM_WIDTH'((1 << PWM_WIDTH) - 2);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                 state_reg, state_next;
  logic [PRE_W-1:0]       pre_cnt_reg;
  logic [SPEED_WIDTH-1:0] step_cnt_reg;
  logic [SPEED_WIDTH-1:0] speed_q_reg;
  logic [PWM_WIDTH-1:0]   pwm_cnt_reg;
  logic [PWM_WIDTH-1:0]   bright_q_reg;
  logic                   next_pos_reg;

  logic advance;
  logic base_tick;
  logic step_done;
  logic pwm_wrap;

  // Counters advance on every active edge that sees pause low, so an edge
  // spent paused is neither lost nor counted twice.
  assign advance   = (state_reg != IDLE) && enable && !pause;
  assign base_tick = advance && (pre_cnt_reg == PRE_MAX);
  assign step_done = base_tick && (step_cnt_reg == speed_q_reg);
  assign pwm_wrap  = (pwm_cnt_reg == PWM_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (enable) state_next = RUN;
      RUN, HOLD: begin
        if (!enable)    state_next = IDLE;
        else if (pause) state_next = HOLD;
        else            state_next = RUN;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_reg  <= '0;
      step_cnt_reg <= '0;
      speed_q_reg  <= '0;
      pwm_cnt_reg  <= '0;
      bright_q_reg <= '0;
      next_pos_reg <= 1'b0;
    end else if (state_reg == IDLE || !enable) begin
      pre_cnt_reg  <= '0;
      step_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
      next_pos_reg <= 1'b0;
      if (state_reg == IDLE && enable) begin
        speed_q_reg  <= speed;
        bright_q_reg <= brightness;
      end
    end else begin
      next_pos_reg <= step_done;
      if (advance) begin
        pre_cnt_reg <= base_tick ? '0 : pre_cnt_reg + 1'b1;
      end
      if (base_tick) begin
        step_cnt_reg <= step_done ? '0 : step_cnt_reg + 1'b1;
      end
      if (step_done) begin
        speed_q_reg <= speed;
      end
      // PWM runs through HOLD so the LEDs keep their brightness while paused.
      pwm_cnt_reg <= pwm_wrap ? '0 : pwm_cnt_reg + 1'b1;
      if (pwm_wrap) begin
        bright_q_reg <= brightness;
      end
    end
  end

  always_comb begin
    running    = (state_reg != IDLE);
    pwm_enable = running && (pwm_cnt_reg < bright_q_reg);
    next_pos   = next_pos_reg;
  end

endmodule

// File: tb/tb_light_step_timer.sv
// Directed bench for light_step_timer with BASE_PERIOD=4, 3-bit speed, 4-bit PWM.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_light_step_timer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pause;
  logic [2:0] speed;
  logic [3:0] brightness;
  logic       next_pos;
  logic       pwm_enable;
  logic       running;

  int errors = 0;
  int checks = 0;

  light_step_timer #(
    .BASE_PERIOD(4),
    .SPEED_WIDTH(3),
    .PWM_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pause     (pause),
    .speed     (speed),
    .brightness(brightness),
    .next_pos  (next_pos),
    .pwm_enable(pwm_enable),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until next_pos is seen high; -1 if it never appears within max.
  task automatic cycles_to_pulse(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (next_pos) begin
        n = i;
        break;
      end
    end
  endtask

  // Samples pwm_enable over 15 consecutive cycles, starting with the current one.
  task automatic count_pwm(output int highs);
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      if (pwm_enable) highs++;
      tick();
    end
  endtask

  task automatic restart(input logic [2:0] spd, input logic [3:0] br);
    enable = 1'b0;
    tick();
    check("idle_running", running, 0);
    speed      = spd;
    brightness = br;
    enable     = 1'b1;
    tick();
  endtask

  int n;
  int highs;
  int pulses;

  initial begin
    reset = 1'b1; enable = 1'b0; pause = 1'b0; speed = 3'd0; brightness = 4'd0;
    #2 reset = 1'b0;
    #1;
    check("rst_next_pos", next_pos, 0);
    check("rst_pwm", pwm_enable, 0);
    check("rst_running", running, 0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    check("idle_hold", running, 0);

    // 1: speed=1 -> N=8
    speed = 3'd1; enable = 1'b1;
    tick();
    check("t1_entry_running", running, 1);
    cycles_to_pulse(20, n);
    check("t1_first", n, 8);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t1_width", next_pos, 0);
      cycles_to_pulse(20, n);
      check("t1_interval_rest", n, 7);
    end

    // 2: speed 0 -> 3 mid-period
    restart(3'd0, 4'd0);
    cycles_to_pulse(20, n);
    check("t2_first", n, 4);
    cycles_to_pulse(20, n);
    check("t2_interval_fast", n, 4);
    tick(); tick();
    speed = 3'd3;
    cycles_to_pulse(20, n);
    check("t2_finish_old_rate", n, 2);
    cycles_to_pulse(40, n);
    check("t2_interval_slow", n, 16);
    cycles_to_pulse(40, n);
    check("t2_interval_slow2", n, 16);

    // 3: pause with step_cnt=1, pre_cnt=2, speed=2
    restart(3'd2, 4'd5);
    for (int k = 0; k < 6; k++) tick();
    pause = 1'b1;
    pulses = 0; highs = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (next_pos) pulses++;
      if (pwm_enable) highs++;
    end
    check("t3_no_pulse_paused", pulses, 0);
    check("t3_pwm_highs_paused", highs, 2);
    check("t3_running_hold", running, 1);
    pause = 1'b0;
    cycles_to_pulse(20, n);
    check("t3_resume", n, 6);

    // 4: PWM duty and boundary-aligned brightness changes
    restart(3'd7, 4'd5);
    check("t4_first_high", pwm_enable, 1);
    count_pwm(highs);
    check("t4_duty5", highs, 5);
    brightness = 4'd15;
    count_pwm(highs);
    check("t4_change_deferred", highs, 5);
    count_pwm(highs);
    check("t4_duty15", highs, 15);
    tick(); tick(); tick();
    brightness = 4'd0;
    count_pwm(highs);
    check("t4_mid_change", highs, 12);
    count_pwm(highs);
    check("t4_duty0", highs, 0);

    // 5: enable drops on the step-completing edge
    restart(3'd1, 4'd15);
    for (int k = 0; k < 7; k++) tick();
    check("t5_no_early_pulse", next_pos, 0);
    enable = 1'b0;
    tick();
    check("t5_next_pos", next_pos, 0);
    check("t5_running", running, 0);
    check("t5_pwm", pwm_enable, 0);
    enable = 1'b1;
    tick();
    cycles_to_pulse(20, n);
    check("t5_reenable_full_wait", n, 8);

    // 6: asynchronous reset during a pulse
    #2 reset = 1'b0;
    #1;
    check("t6_next_pos_async", next_pos, 0);
    check("t6_running_async", running, 0);
    check("t6_pwm_async", pwm_enable, 0);
    enable = 1'b0;
    #3 reset = 1'b1;
    tick(); tick(); tick();
    check("t6_stay_idle", running, 0);
    enable = 1'b1;
    tick();
    check("t6_running", running, 1);
    cycles_to_pulse(20, n);
    check("t6_first", n, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/light_step_timer.md
Name: light_step_timer

Overview:
Timing source for the LED scanner. It produces the one-cycle step strobe `next_pos`, which advances the scanner by one position, and the PWM brightness gate `pwm_enable`, which is ANDed onto every LED. It sits between the top-level speed/brightness controls and the scanner, which consumes both outputs directly. Step rate and brightness are runtime-selectable, and new values are applied glitch-free on period boundaries.

Parameters:
- BASE_PERIOD, 1000: clocks per base tick. Must be ≥2. Benches use 4.
- SPEED_WIDTH, 3: width of `speed`. Step period = BASE_PERIOD*(speed+1) clocks.
- PWM_WIDTH, 4: width of `brightness` and the PWM counter. PWM period = 2^PWM_WIDTH-1 clocks.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- enable  in  1  run request; low forces IDLE.
- pause  in  1  freezes stepping while high; PWM keeps running.
- speed  in  SPEED_WIDTH  step-period select; 0 is fastest.
- brightness  in  PWM_WIDTH  duty level; 0 = off, all-ones = always on.
- next_pos  out  1  registered single-cycle step strobe.
- pwm_enable  out  1  LED gate, decoded from registered state only.
- running  out  1  high in RUN or HOLD.

Behaviour:
- States: IDLE, RUN, HOLD.
- Reset (reset=0, asynchronous):
  - state=IDLE; pre_cnt, step_cnt, pwm_cnt, speed_q, bright_q all 0.
  - next_pos=0, pwm_enable=0, running=0.
- IDLE:
  - All counters held at 0; outputs 0.
  - When enable=1 at an edge, go to RUN and capture speed_q<=speed and bright_q<=brightness at that edge.
- RUN:
  - pre_cnt counts 0..BASE_PERIOD-1 and wraps; the wrap cycle is a base tick.
  - On each base tick, step_cnt increments. On the base tick where step_cnt==speed_q:
    - step_cnt<=0;
    - next_pos<=1 for exactly the following cycle;
    - speed_q<=speed (new speed takes effect on the next step only).
  - First next_pos is high in cycle N after the entry edge, where N = BASE_PERIOD*(speed_q+1). Pulses then repeat every N cycles.
- HOLD:
  - Entered from RUN when pause=1 and enable=1.
  - pre_cnt and step_cnt frozen; next_pos=0.
  - Return to RUN when pause=0; counting resumes from the frozen values, so no partial period is lost or repeated.
- Priority at any edge: reset > enable=0 (go to IDLE, clear counters, next_pos<=0) > pause > step.
  - pause=1 on the cycle a step would complete suppresses that step; it completes after resume.
- PWM (RUN and HOLD only):
  - pwm_cnt counts 0..2^PWM_WIDTH-2 and wraps.
  - On wrap, bright_q<=brightness.
  - pwm_enable = running & (pwm_cnt < bright_q).
  - Duty is bright_q/(2^PWM_WIDTH-1): brightness 0 gives constant 0; all-ones gives constant 1.
- running=1 in RUN and HOLD, registered with the state.
- Width rule: step_cnt is SPEED_WIDTH bits and compares against speed_q, so no overflow occurs. All counters are unsigned.
- Reset mid-operation: all outputs drop in the same cycle reset is asserted. After reset release, the block stays in IDLE until enable is sampled high.

Test Plan:
1. Reset, then enable=1, speed=1, BASE_PERIOD=4 → first next_pos 8 cycles after the entry edge, then every 8 cycles, each pulse exactly 1 cycle wide.
2. speed=0 → 3 mid-run → the current period finishes at the old rate; the following interval is 16 cycles; no double or short pulse.
3. pause=1 for 10 cycles at step_cnt=1, pre_cnt=2 → no next_pos during pause; next_pos 2+4=6 cycles after pause falls; pwm_enable keeps toggling.
4. brightness=5, PWM_WIDTH=4 → pwm_enable high 5 of every 15 cycles. brightness=0 → constant 0. brightness=15 → constant 1. A change mid-period is applied only after pwm_cnt wraps.
5. enable drops on the same edge a step completes → no next_pos; state IDLE with all outputs 0 next cycle. Re-enable → full N-cycle wait before the first pulse.
6. Assert reset asynchronously mid-RUN between edges → outputs 0 immediately; after release, the block stays in IDLE until enable=1.
